gpio_in_cond: RTL and testbench
===============================

GPIO_IN_COND -- requirements
Module: gpio_in_cond

Interface
REQ-001 SHALL have parameter N_GPIO, default 32: number of GPIO pins conditioned.
REQ-002 SHALL have parameter CNT_W, default 8: width of the per-pin debounce counter and of the limit input.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: the reset is synchronous and active-high.
REQ-005 SHALL have port i_gpio_raw, input, N_GPIO bits: asynchronous pad-cell C outputs.
REQ-006 SHALL have port en_gpio, input, N_GPIO bits: pad OEN per pin; 1 = input mode (conditioned), 0 = output mode (pin frozen).
REQ-007 SHALL have port i_deb_limit, input, CNT_W bits: stable-cycle count required before a change is accepted.
REQ-008 SHALL have port i_mask_rise, input, N_GPIO bits: rising-edge interrupt enable per pin.
REQ-009 SHALL have port i_mask_fall, input, N_GPIO bits: falling-edge interrupt enable per pin.
REQ-010 SHALL have port i_irq_clr, input, N_GPIO bits: one-cycle write-1-to-clear for pending bits.
REQ-011 SHALL have port o_gpio_sync, output, N_GPIO bits: 2-flop synchronised raw value.
REQ-012 SHALL have port o_gpio_deb, output, N_GPIO bits: debounced value (registered).
REQ-013 SHALL have port o_rise, output, N_GPIO bits: one-cycle pulse on debounced 0->1.
REQ-014 SHALL have port o_fall, output, N_GPIO bits: one-cycle pulse on debounced 1->0.
REQ-015 SHALL have port o_irq_pending, output, N_GPIO bits: sticky per-pin interrupt flags.
REQ-016 SHALL have port o_irq, output, 1 bit: OR-reduction of o_irq_pending (combinational).

Function
REQ-017 SHALL pass each raw bit through two flops (s1, s2); o_gpio_sync = s2; 2-edge latency.
REQ-018 SHALL keep per pin a counter cnt and registered deb; each edge with en_gpio=1: if s2==deb, cnt<=0; else if cnt>=i_deb_limit, deb<=s2 and cnt<=0; else cnt<=cnt+1.
REQ-019 SHALL therefore update deb L+3 edges after the raw change is first sampled, for limit L held constant and raw stable; L=0 gives 2-edge-after-sync (3 total).
REQ-020 SHALL restart the count (cnt<=0) whenever s2 returns to deb before acceptance; glitches shorter than L+1 synced cycles never reach o_gpio_deb.
REQ-021 SHALL compare with >= so that lowering i_deb_limit below a running cnt accepts the change on the next edge; counter SHALL saturate, never wrap.
REQ-022 SHALL, with en_gpio=0 for a pin, hold deb, force cnt<=0, and suppress o_rise/o_fall for that pin; synchroniser still runs.
REQ-023 SHALL keep a registered deb_prev; o_rise = deb & ~deb_prev, o_fall = ~deb & deb_prev; each pulse exactly one cycle, coincident with the first cycle o_gpio_deb shows the new value.
REQ-024 SHALL set pending on the edge after (o_rise & i_mask_rise) | (o_fall & i_mask_fall); masking later does not clear pending.
REQ-025 SHALL clear pending bit on edge where i_irq_clr bit is 1; simultaneous set and clear on same bit: set wins.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, clear s1, s2, deb, deb_prev, cnt, pending to 0 regardless of state; all outputs read 0 the cycle after.
REQ-027 SHALL, on reset mid-debounce, discard the count; no rise/fall pulse generated by the reset transition itself.

Verification
REQ-028 L=4, pin0 raw 0->1 held -> o_gpio_deb[0]=1 exactly 7 edges later, o_rise[0] pulses 1 cycle; pending[0]=1 next edge if mask_rise[0]=1.
REQ-029 L=4, raw pulse 3 synced cycles high -> o_gpio_deb stays 0, no o_rise, cnt returns 0.
REQ-030 Pending[5]=1 with new fall event and i_irq_clr[5]=1 same edge -> pending[5] stays 1; clr alone next cycle -> 0, o_irq=0.
REQ-031 L=200, cnt at 100, limit rewritten to 10 -> deb updates on next edge.
REQ-032 en_gpio[3]=0, raw[3] toggling -> o_gpio_sync[3] follows, o_gpio_deb[3] and pulses frozen; en back to 1 -> normal debounce from cnt=0.
REQ-033 reset asserted with deb=all-ones and counts running -> all outputs 0 next cycle, no edge pulses.

Source files
------------

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: per-pin 2-flop synchroniser, saturating debounce
// counter, edge detection and sticky maskable interrupt flags.
module gpio_in_cond #(
    parameter int unsigned N_GPIO = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_GPIO-1:0] i_gpio_raw,
    input  logic [N_GPIO-1:0] en_gpio,
    input  logic [CNT_W-1:0]  i_deb_limit,
    input  logic [N_GPIO-1:0] i_mask_rise,
    input  logic [N_GPIO-1:0] i_mask_fall,
    input  logic [N_GPIO-1:0] i_irq_clr,
    output logic [N_GPIO-1:0] o_gpio_sync,
    output logic [N_GPIO-1:0] o_gpio_deb,
    output logic [N_GPIO-1:0] o_rise,
    output logic [N_GPIO-1:0] o_fall,
    output logic [N_GPIO-1:0] o_irq_pending,
    output logic              o_irq
);

    logic [N_GPIO-1:0]            s1_d, s1_q;
    logic [N_GPIO-1:0]            s2_d, s2_q;
    logic [N_GPIO-1:0]            deb_d, deb_q;
    logic [N_GPIO-1:0]            deb_prev_d, deb_prev_q;
    logic [N_GPIO-1:0]            pending_d, pending_q;
    logic [N_GPIO-1:0][CNT_W-1:0] cnt_d, cnt_q;
    logic [N_GPIO-1:0]            irq_set;

    // Synchroniser, debounce counters and deb history next-state.
    always_comb begin
        s1_d       = i_gpio_raw;
        s2_d       = s1_q;
        deb_d      = deb_q;
        cnt_d      = cnt_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < int'(N_GPIO); i++) begin
            if (!en_gpio[i]) begin
                // Output-mode pin: value frozen, count discarded.
                cnt_d[i] = '0;
            end else if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= i_deb_limit) begin
                // >= so a lowered limit accepts a long-running count at once.
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
            end else if (cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge pulses are valid in the first cycle deb shows its new value.
    always_comb begin
        o_rise = deb_q & ~deb_prev_q & en_gpio;
        o_fall = ~deb_q & deb_prev_q & en_gpio;
    end

    // Sticky pending flags; a new event beats a simultaneous clear.
    always_comb begin
        irq_set   = (o_rise & i_mask_rise) | (o_fall & i_mask_fall);
        pending_d = (pending_q & ~i_irq_clr) | irq_set;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '0;
            pending_q  <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
        end
    end

    // Registered outputs and combinational interrupt summary.
    always_comb begin
        o_gpio_sync   = s2_q;
        o_gpio_deb    = deb_q;
        o_irq_pending = pending_q;
        o_irq         = |pending_q;
    end

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed self-checking bench for gpio_in_cond (default 32 pins, 8-bit counter).
module tb_gpio_in_cond;

    logic        clk;
    logic        reset;
    logic [31:0] i_gpio_raw;
    logic [31:0] en_gpio;
    logic [7:0]  i_deb_limit;
    logic [31:0] i_mask_rise;
    logic [31:0] i_mask_fall;
    logic [31:0] i_irq_clr;
    logic [31:0] o_gpio_sync;
    logic [31:0] o_gpio_deb;
    logic [31:0] o_rise;
    logic [31:0] o_fall;
    logic [31:0] o_irq_pending;
    logic        o_irq;

    int n_total;
    int n_pass;

    gpio_in_cond #(
        .N_GPIO(32),
        .CNT_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_gpio_raw   (i_gpio_raw),
        .en_gpio      (en_gpio),
        .i_deb_limit  (i_deb_limit),
        .i_mask_rise  (i_mask_rise),
        .i_mask_fall  (i_mask_fall),
        .i_irq_clr    (i_irq_clr),
        .o_gpio_sync  (o_gpio_sync),
        .o_gpio_deb   (o_gpio_deb),
        .o_rise       (o_rise),
        .o_fall       (o_fall),
        .o_irq_pending(o_irq_pending),
        .o_irq        (o_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        reset       = 1'b1;
        i_gpio_raw  = '0;
        en_gpio     = '1;
        i_deb_limit = 8'd4;
        i_mask_rise = '0;
        i_mask_fall = '0;
        i_irq_clr   = '0;
        tick(2);
        reset = 1'b0;
        check_eq("rst_sync", o_gpio_sync, 32'h0);
        check_eq("rst_deb", o_gpio_deb, 32'h0);
        check_eq("rst_rise", o_rise, 32'h0);
        check_eq("rst_fall", o_fall, 32'h0);
        check_eq("rst_pend", o_irq_pending, 32'h0);
        check_eq("rst_irq", {31'b0, o_irq}, 32'h0);

        // L=4, pin0 raw 0->1 held: deb exactly 7 edges later, then pending.
        i_mask_rise[0] = 1'b1;
        i_gpio_raw[0]  = 1'b1;
        tick(1);
        check_eq("p0_sync_e1", o_gpio_sync, 32'h0);
        tick(1);
        check_eq("p0_sync_e2", o_gpio_sync, 32'h1);
        tick(4);
        check_eq("p0_deb_e6", o_gpio_deb, 32'h0);
        check_eq("p0_rise_e6", o_rise, 32'h0);
        tick(1);
        check_eq("p0_deb_e7", o_gpio_deb, 32'h1);
        check_eq("p0_rise_e7", o_rise, 32'h1);
        check_eq("p0_pend_e7", o_irq_pending, 32'h0);
        tick(1);
        check_eq("p0_rise_e8", o_rise, 32'h0);
        check_eq("p0_pend_e8", o_irq_pending, 32'h1);
        check_eq("p0_irq_e8", {31'b0, o_irq}, 32'h1);
        i_irq_clr[0] = 1'b1;
        tick(1);
        i_irq_clr[0] = 1'b0;
        check_eq("p0_pend_clr", o_irq_pending, 32'h0);

        // Pin1 glitch, 3 synced cycles high: never accepted.
        i_gpio_raw[1] = 1'b1;
        tick(3);
        i_gpio_raw[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check_eq("p1_glitch_deb", o_gpio_deb, 32'h1);
            check_eq("p1_glitch_rise", o_rise, 32'h0);
        end
        // Then a held change is accepted at the normal 7-edge latency.
        i_gpio_raw[1] = 1'b1;
        tick(6);
        check_eq("p1_deb_e6", o_gpio_deb, 32'h1);
        tick(1);
        check_eq("p1_deb_e7", o_gpio_deb, 32'h3);
        check_eq("p1_rise_e7", o_rise, 32'h2);

        // Pin5: pending set, then fall event with clear on the same edge.
        i_mask_rise[5] = 1'b1;
        i_mask_fall[5] = 1'b1;
        i_gpio_raw[5]  = 1'b1;
        tick(7);
        check_eq("p5_deb_up", o_gpio_deb, 32'h23);
        check_eq("p5_rise", o_rise, 32'h20);
        tick(1);
        check_eq("p5_pend_set", o_irq_pending, 32'h20);
        i_gpio_raw[5] = 1'b0;
        tick(6);
        check_eq("p5_fall_e6", o_fall, 32'h0);
        tick(1);
        check_eq("p5_fall_e7", o_fall, 32'h20);
        check_eq("p5_deb_dn", o_gpio_deb, 32'h3);
        i_irq_clr[5] = 1'b1;
        tick(1);
        check_eq("p5_set_wins", o_irq_pending, 32'h20);
        tick(1);
        i_irq_clr[5] = 1'b0;
        check_eq("p5_clr", o_irq_pending, 32'h0);
        check_eq("p5_irq_low", {31'b0, o_irq}, 32'h0);

        // Pin2: L=200, cnt reaches 100, limit lowered to 10 -> accept next edge.
        i_deb_limit   = 8'd200;
        i_gpio_raw[2] = 1'b1;
        tick(102);
        check_eq("p2_deb_cnt100", o_gpio_deb, 32'h3);
        i_deb_limit = 8'd10;
        tick(1);
        check_eq("p2_deb_lowered", o_gpio_deb, 32'h7);
        check_eq("p2_rise", o_rise, 32'h4);
        i_deb_limit = 8'd4;

        // Pin3 in output mode: sync follows, deb and pulses frozen.
        en_gpio[3]    = 1'b0;
        i_gpio_raw[3] = 1'b1;
        tick(2);
        check_eq("p3_sync_hi", o_gpio_sync, 32'hF);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check_eq("p3_frozen_deb", o_gpio_deb, 32'h7);
            check_eq("p3_frozen_rise", o_rise, 32'h0);
        end
        i_gpio_raw[3] = 1'b0;
        tick(2);
        check_eq("p3_sync_lo", o_gpio_sync, 32'h7);
        check_eq("p3_fall_none", o_fall, 32'h0);
        i_gpio_raw[3] = 1'b1;
        tick(2);
        // Re-enable: count starts from zero, accept on the 5th edge.
        en_gpio[3] = 1'b1;
        tick(4);
        check_eq("p3_en_e4", o_gpio_deb, 32'h7);
        tick(1);
        check_eq("p3_en_e5", o_gpio_deb, 32'hF);
        check_eq("p3_en_rise", o_rise, 32'h8);

        // Reset with deb all-ones and counts running.
        i_mask_rise = '1;
        i_deb_limit = 8'd0;
        i_gpio_raw  = '1;
        tick(3);
        check_eq("all_deb_l0", o_gpio_deb, 32'hFFFF_FFFF);
        tick(3);
        i_deb_limit = 8'd4;
        i_gpio_raw  = '0;
        tick(3);
        i_gpio_raw = '1;
        reset      = 1'b1;
        tick(1);
        check_eq("rr_sync", o_gpio_sync, 32'h0);
        check_eq("rr_deb", o_gpio_deb, 32'h0);
        check_eq("rr_rise", o_rise, 32'h0);
        check_eq("rr_fall", o_fall, 32'h0);
        check_eq("rr_pend", o_irq_pending, 32'h0);
        check_eq("rr_irq", {31'b0, o_irq}, 32'h0);
        i_gpio_raw = '0;
        reset      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check_eq("post_rst_deb", o_gpio_deb, 32'h0);
            check_eq("post_rst_fall", o_fall, 32'h0);
            check_eq("post_rst_rise", o_rise, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
